// File: rtl/axi_read_responder_pkg.sv
// axi_read_responder_pkg: state encodings and response constants for the AXI read responder
package axi_read_responder_pkg;
   typedef enum logic [1:0] {
      RESPSTATE_IDLE,
      RESPSTATE_FETCH,
      RESPSTATE_LATCH,
      RESPSTATE_SEND
   } resp_state_e;
   localparam logic [1:0] RRESP_OKAY   = 2'b00;
   localparam logic [1:0] RRESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_INCR   = 2'b01;
   localparam logic [2:0] SIZE_4B      = 3'b010;
endpackage

// File: rtl/axi_read_responder_if.sv
// axi_read_responder_if: AXI AR and R channel signals with master/slave views
interface axi_read_responder_if #(
   parameter int ID_W   = 8,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ID_W-1:0]   ARID;
   logic [ADDR_W-1:0] ARADDR;
   logic [3:0]        ARLEN;
   logic [2:0]        ARSIZE;
   logic [1:0]        ARBURST;
   logic              ARVALID;
   logic              ARREADY;
   logic [ID_W-1:0]   RID;
   logic [DATA_W-1:0] RDATA;
   logic [1:0]        RRESP;
   logic              RLAST;
   logic              RVALID;
   logic              RREADY;
   modport master (
      output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
      input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
   );
   modport slave (
      input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
      output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
   );
endinterface

// File: rtl/axi_read_responder.sv
// axi_read_responder: one-at-a-time INCR read bursts from a single-port synchronous SRAM onto the R channel
module axi_read_responder
   import axi_read_responder_pkg::*;
#(
   parameter int ID_W   = 8,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int MEM_AW = 14
) (
   input  logic                ACLK,
   input  logic                ARESET,
   axi_read_responder_if.slave bus,
   output logic                mem_cs,
   output logic [MEM_AW-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   mem_rdata
);
   resp_state_e       state, state_n;
   logic [ID_W-1:0]   id;
   logic [3:0]        beats;
   logic [MEM_AW-1:0] waddr;
   logic [DATA_W-1:0] rdata;
   logic              err, ar_hs, r_hs, last, ar_err;
   logic              unused;
   assign unused = ^{bus.ARADDR[ADDR_W-1:MEM_AW+2], bus.ARADDR[1:0]};
   always_comb begin
      ar_hs   = bus.ARVALID && state == RESPSTATE_IDLE;
      r_hs    = bus.RREADY && state == RESPSTATE_SEND;
      last    = beats == 4'd0;
      ar_err  = bus.ARBURST != BURST_INCR || bus.ARSIZE != SIZE_4B;
      state_n = state;
      unique case (state)
         RESPSTATE_IDLE:  state_n = !ar_hs ? RESPSTATE_IDLE : ar_err ? RESPSTATE_SEND : RESPSTATE_FETCH;
         RESPSTATE_FETCH: state_n = RESPSTATE_LATCH;
         RESPSTATE_LATCH: state_n = RESPSTATE_SEND;
         RESPSTATE_SEND:  state_n = !r_hs ? RESPSTATE_SEND : last ? RESPSTATE_IDLE :
                                    err ? RESPSTATE_SEND : RESPSTATE_FETCH;
         default:         state_n = RESPSTATE_IDLE;
      endcase
   end
   // Error bursts never touch the SRAM, so the cleared data register is what they return.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state <= RESPSTATE_IDLE;
         id    <= '0;
         beats <= '0;
         waddr <= '0;
         rdata <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_n;
         if (ar_hs) begin
            id    <= bus.ARID;
            beats <= bus.ARLEN;
            waddr <= bus.ARADDR[MEM_AW+1:2];
            err   <= ar_err;
            rdata <= '0;
         end
         if (state == RESPSTATE_LATCH) rdata <= mem_rdata;
         if (r_hs && !last) begin
            beats <= beats - 4'd1;
            waddr <= waddr + 1'b1;
         end
      end
   end
   assign bus.ARREADY = state == RESPSTATE_IDLE;
   assign bus.RVALID  = state == RESPSTATE_SEND;
   assign bus.RID     = id;
   assign bus.RDATA   = rdata;
   assign bus.RRESP   = (state == RESPSTATE_SEND && err) ? RRESP_SLVERR : RRESP_OKAY;
   assign bus.RLAST   = state == RESPSTATE_SEND && last;
   assign mem_cs      = state == RESPSTATE_FETCH;
   assign mem_addr    = waddr;
endmodule

// File: tb/tb_axi_read_responder.sv
// tb_axi_read_responder: directed stimulus with a queue scoreboard for R beats and SRAM addresses
module tb_axi_read_responder;
   typedef struct packed {
      logic [7:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } beat_t;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b1;
   logic        mem_cs;
   logic [13:0] mem_addr;
   logic [31:0] mem_rdata = '0;
   logic [31:0] mem [0:16383];
   int          checks = 0, errors = 0, cyc = 0, last_hs = -1;
   beat_t       rq[$];
   logic [13:0] aq[$];

   axi_read_responder_if #(.ID_W(8), .ADDR_W(32), .DATA_W(32)) bus();

   axi_read_responder #(.ID_W(8), .ADDR_W(32), .DATA_W(32), .MEM_AW(14)) dut (
      .ACLK(ACLK),
      .ARESET(ARESET),
      .bus(bus),
      .mem_cs(mem_cs),
      .mem_addr(mem_addr),
      .mem_rdata(mem_rdata)
   );

   always #5 ACLK = ~ACLK;

   always @(posedge ACLK) begin
      cyc <= cyc + 1;
      if (mem_cs) mem_rdata <= mem[mem_addr];
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic beat_t bt(input logic [7:0] id, input logic [31:0] data, input logic [1:0] resp, input logic last);
      return {id, data, resp, last};
   endfunction

   // Monitor: compare every presented beat against the queue head; pop on handshake.
   always @(negedge ACLK) begin
      beat_t e;
      if (!ARESET) begin
         if (bus.RVALID) begin
            if (rq.size() == 0) begin
               if (bus.RREADY) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: got data %0h expected no beat", bus.RDATA);
               end
            end else begin
               e = rq[0];
               chk("rid", bus.RID, e.id);
               chk("rdata", bus.RDATA, e.data);
               chk("rresp", bus.RRESP, e.resp);
               chk("rlast", bus.RLAST, e.last);
               if (bus.RREADY) void'(rq.pop_front());
            end
            if (bus.RREADY && bus.RLAST) last_hs = cyc;
         end
         if (mem_cs) begin
            if (aq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_mem_cs: got addr %0h expected no access", mem_addr);
            end else chk("mem_addr", mem_addr, aq.pop_front());
         end
      end
   end

   task automatic ar(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                     input logic [2:0] size, input logic [1:0] burst, output int t);
      int n = 0;
      @(posedge ACLK);
      #1;
      bus.ARID = id;
      bus.ARADDR = addr;
      bus.ARLEN = len;
      bus.ARSIZE = size;
      bus.ARBURST = burst;
      bus.ARVALID = 1'b1;
      @(negedge ACLK);
      while (!bus.ARREADY && n < 100) begin
         @(negedge ACLK);
         n++;
      end
      chk("ar_accept", bus.ARREADY, 1);
      t = cyc;
      @(posedge ACLK);
      #1 bus.ARVALID = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((rq.size() != 0 || aq.size() != 0) && n < 200) begin
         @(negedge ACLK);
         n++;
      end
      chk("drain_left", rq.size() + aq.size(), 0);
      rq.delete();
      aq.delete();
   endtask

   task automatic wait_rvalid();
      int n = 0;
      while (!bus.RVALID && n < 50) begin
         @(negedge ACLK);
         n++;
      end
      chk("rvalid_seen", bus.RVALID, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int t, n;
      logic [3:0] pat = 4'b1001;
      mem[4] = 32'hDEADBEEF;
      for (int i = 0; i < 4; i++) mem[64+i] = 32'hA0 + i;
      for (int i = 0; i < 8; i++) mem[256+i] = 32'hB0 + i;
      mem[14'h3FFF] = 32'h1111_1111;
      mem[0] = 32'h2222_2222;
      bus.ARVALID = 1'b0;
      bus.ARID = '0;
      bus.ARADDR = '0;
      bus.ARLEN = '0;
      bus.ARSIZE = '0;
      bus.ARBURST = '0;
      bus.RREADY = 1'b1;
      repeat (3) @(posedge ACLK);
      #1 ARESET = 1'b0;
      @(negedge ACLK);
      chk("rst_arready", bus.ARREADY, 1);
      chk("rst_rvalid", bus.RVALID, 0);
      chk("rst_rlast", bus.RLAST, 0);
      chk("rst_rid", bus.RID, 0);
      chk("rst_rdata", bus.RDATA, 0);
      chk("rst_rresp", bus.RRESP, 0);
      chk("rst_mem_cs", mem_cs, 0);
      chk("rst_mem_addr", mem_addr, 0);

      rq.push_back(bt(8'h12, 32'hDEADBEEF, 2'b00, 1'b1));
      aq.push_back(14'd4);
      ar(8'h12, 32'h10, 4'd0, 3'd2, 2'b01, t);
      @(negedge ACLK) chk("single_cs_t1", mem_cs, 1);
      @(negedge ACLK) chk("single_rvalid_t2", bus.RVALID, 0);
      @(negedge ACLK) chk("single_rvalid_t3", bus.RVALID, 1);
      drain();

      for (int i = 0; i < 4; i++) begin
         rq.push_back(bt(8'h03, 32'hA0 + i, 2'b00, i == 3));
         aq.push_back(14'd64 + i[13:0]);
      end
      ar(8'h03, 32'h100, 4'd3, 3'd2, 2'b01, t);
      for (int k = 0; k < 80 && (rq.size() != 0 || aq.size() != 0); k++) begin
         bus.RREADY = pat[k%4];
         @(posedge ACLK);
         #1;
      end
      bus.RREADY = 1'b1;
      drain();

      rq.push_back(bt(8'h07, 32'h1111_1111, 2'b00, 1'b0));
      rq.push_back(bt(8'h07, 32'h2222_2222, 2'b00, 1'b1));
      aq.push_back(14'h3FFF);
      aq.push_back(14'h0000);
      ar(8'h07, 32'h0000_FFFC, 4'd1, 3'd2, 2'b01, t);
      drain();

      for (int i = 0; i < 3; i++) rq.push_back(bt(8'h34, 32'h0, 2'b10, i == 2));
      ar(8'h34, 32'h200, 4'd2, 3'd2, 2'b10, t);
      @(negedge ACLK);
      chk("err_rvalid_t1", bus.RVALID, 1);
      chk("err_rlast_t1", bus.RLAST, 0);
      @(negedge ACLK) chk("err_rvalid_t2", bus.RVALID, 1);
      @(negedge ACLK);
      chk("err_rvalid_t3", bus.RVALID, 1);
      chk("err_rlast_t3", bus.RLAST, 1);
      @(negedge ACLK) chk("err_rvalid_t4", bus.RVALID, 0);
      drain();

      bus.RREADY = 1'b0;
      rq.push_back(bt(8'h05, 32'hB0, 2'b00, 1'b0));
      aq.push_back(14'd256);
      aq.push_back(14'd257);
      ar(8'h05, 32'h400, 4'd7, 3'd2, 2'b01, t);
      wait_rvalid();
      @(posedge ACLK);
      #1 bus.RREADY = 1'b1;
      @(posedge ACLK);
      #1 bus.RREADY = 1'b0;
      wait_rvalid();
      chk("rst_mid_beat2_data", bus.RDATA, 32'hB1);
      chk("rst_mid_beat2_last", bus.RLAST, 0);
      @(posedge ACLK);
      #1 ARESET = 1'b1;
      @(posedge ACLK);
      #1 ARESET = 1'b0;
      @(negedge ACLK);
      chk("rst_mid_rvalid", bus.RVALID, 0);
      chk("rst_mid_arready", bus.ARREADY, 1);
      chk("rst_mid_rdata", bus.RDATA, 0);
      chk("rst_mid_mem_cs", mem_cs, 0);
      chk("rst_mid_aq", aq.size(), 0);
      rq.delete();
      aq.delete();
      bus.RREADY = 1'b1;
      rq.push_back(bt(8'h56, 32'hDEADBEEF, 2'b00, 1'b1));
      aq.push_back(14'd4);
      ar(8'h56, 32'h10, 4'd0, 3'd2, 2'b01, t);
      drain();

      rq.push_back(bt(8'h01, 32'hA0, 2'b00, 1'b0));
      rq.push_back(bt(8'h01, 32'hA1, 2'b00, 1'b1));
      rq.push_back(bt(8'h02, 32'hDEADBEEF, 2'b00, 1'b1));
      aq.push_back(14'd64);
      aq.push_back(14'd65);
      aq.push_back(14'd4);
      ar(8'h01, 32'h100, 4'd1, 3'd2, 2'b01, t);
      bus.ARID = 8'h02;
      bus.ARADDR = 32'h10;
      bus.ARLEN = 4'd0;
      bus.ARSIZE = 3'd2;
      bus.ARBURST = 2'b01;
      bus.ARVALID = 1'b1;
      n = 0;
      @(negedge ACLK);
      while (!bus.ARREADY && n < 100) begin
         @(negedge ACLK);
         n++;
      end
      chk("b2b_arready", bus.ARREADY, 1);
      chk("b2b_accept_cycle", cyc, last_hs + 1);
      @(posedge ACLK);
      #1 bus.ARVALID = 1'b0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
